// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM access arbiter.
package sram_arb_pkg;

   // Pin-bundle widths of the external SRAM; the top checks its parameters against these.
   localparam int SRAM_ADDR_WIDTH = 16;
   localparam int SRAM_DATA_WIDTH = 16;

   // Requester indices; also the encoding of last_grant.
   localparam logic REQ_0 = 1'b0;
   localparam logic REQ_1 = 1'b1;

   // Access sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD,
      TURN
   } state_t;

   // Request captured at the IDLE handshake and replayed onto the pins.
   typedef struct packed {
      logic                       id;
      logic                       write;
      logic [SRAM_ADDR_WIDTH-1:0] addr;
      logic [SRAM_DATA_WIDTH-1:0] wdata;
      logic [1:0]                 be;
   } sram_req_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Request/response handshake plus SRAM pin bundle shared by the arbiter and its users.
interface sram_access_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);

   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_write;
   logic [ADDR_WIDTH-1:0] req_addr_0;
   logic [ADDR_WIDTH-1:0] req_addr_1;
   logic [DATA_WIDTH-1:0] req_wdata_0;
   logic [DATA_WIDTH-1:0] req_wdata_1;
   logic [1:0]            req_be_0;
   logic [1:0]            req_be_1;
   logic [1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  busy;

   logic [ADDR_WIDTH-1:0] io_address_0;
   logic [DATA_WIDTH-1:0] io_data_write_0;
   logic                  io_data_writeEnable;
   logic [DATA_WIDTH-1:0] io_data_read;
   logic                  io_ce;
   logic                  io_we;
   logic                  io_oe;
   logic                  io_ub;
   logic                  io_lb;

   // Arbiter side: serves requests and drives the SRAM pads.
   modport slave (
      input  req_valid, req_write, req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
             req_be_0, req_be_1, io_data_read,
      output req_ready, rsp_valid, rsp_rdata, busy, io_address_0, io_data_write_0,
             io_data_writeEnable, io_ce, io_we, io_oe, io_ub, io_lb
   );

   // Requester and pad side.
   modport master (
      output req_valid, req_write, req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
             req_be_0, req_be_1, io_data_read,
      input  req_ready, rsp_valid, rsp_rdata, busy, io_address_0, io_data_write_0,
             io_data_writeEnable, io_ce, io_we, io_oe, io_ub, io_lb
   );

endinterface

// File: rtl/sram_rr_arbiter_2.sv
// Two-input round-robin grant; last_grant advances only when update_en is high.
module sram_rr_arbiter_2
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       update_en,
   output logic [1:0] grant
);

   logic last_grant;

   // Grant the lone requester, or on contention the one that was not served last.
   always_comb begin
      // NOTE: default assigned first so no input pattern leaves grant unassigned (no latch).
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == REQ_1) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Remember the winner of each accepted handshake; reset favours requester 0.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst)
         last_grant <= REQ_1;
      else if (update_en)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares an asynchronous 16-bit SRAM between two requesters: round-robin grant,
// then a timed SETUP / ACCESS / HOLD / TURN strobe sequence with registered pins.
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH        = 16,
   parameter int DATA_WIDTH        = 16,
   parameter int ACCESS_CYCLES     = 2,
   parameter int TURNAROUND_CYCLES = 1
)(
   input logic                  PCLK,
   input logic                  RESET,
   sram_access_arbiter_if.slave bus
);

   localparam int CNT_MAX = (ACCESS_CYCLES > TURNAROUND_CYCLES) ? ACCESS_CYCLES : TURNAROUND_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);

   // The latched-request type fixes the pin widths, so the parameters must agree with it.
   if (ADDR_WIDTH != SRAM_ADDR_WIDTH || DATA_WIDTH != SRAM_DATA_WIDTH) begin : g_width_check
      $error("sram_access_arbiter: ADDR_WIDTH/DATA_WIDTH must match sram_arb_pkg widths");
   end
   if (ACCESS_CYCLES < 1 || TURNAROUND_CYCLES < 0) begin : g_timing_check
      $error("sram_access_arbiter: ACCESS_CYCLES must be >= 1, TURNAROUND_CYCLES >= 0");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   sram_req_t        cur, cur_nxt, incoming;
   logic [1:0]       arb_valid, grant;
   logic             accept;

   logic                  ce_nxt, we_nxt, oe_nxt, ub_nxt, lb_nxt, wen_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic [1:0]            rsp_valid_nxt;
   logic                  capture_rdata;

   // Requests are only looked at in IDLE; reset holds req_ready low.
   assign arb_valid     = bus.req_valid & {2{(state == IDLE) && !RESET}};
   assign accept        = |grant;
   assign bus.req_ready = grant;

   sram_rr_arbiter_2 u_rr (
      .clk       (PCLK),
      .rst       (RESET),
      .valid     (arb_valid),
      .update_en (accept),
      .grant     (grant)
   );

   // Select the winning requester's fields for latching.
   always_comb begin
      incoming.id    = grant[1];
      incoming.write = bus.req_write[grant[1]];
      incoming.addr  = grant[1] ? bus.req_addr_1  : bus.req_addr_0;
      incoming.wdata = grant[1] ? bus.req_wdata_1 : bus.req_wdata_0;
      incoming.be    = grant[1] ? bus.req_be_1    : bus.req_be_0;
   end

   // Next-state logic: walk the access phases, counting ACCESS and TURN cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_nxt   = cur;
      case (state)
         IDLE: begin
            if (accept) begin
               cur_nxt   = incoming;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            cnt_nxt   = '0;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (cnt == ACC_LAST) state_nxt = HOLD;
            else                 cnt_nxt   = cnt + 1'b1;
         end
         HOLD: begin
            cnt_nxt   = '0;
            state_nxt = (TURNAROUND_CYCLES == 0) ? IDLE : TURN;
         end
         TURN: begin
            if (cnt == TURN_LAST) state_nxt = IDLE;
            else                  cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin values for the coming cycle, decoded from the next state so the pins are registered.
   always_comb begin
      ce_nxt    = 1'b1;
      we_nxt    = 1'b1;
      oe_nxt    = 1'b1;
      ub_nxt    = 1'b1;
      lb_nxt    = 1'b1;
      wen_nxt   = 1'b0;
      addr_nxt  = bus.io_address_0;
      wdata_nxt = bus.io_data_write_0;
      if (state_nxt == SETUP || state_nxt == ACCESS || state_nxt == HOLD) begin
         ce_nxt   = 1'b0;
         addr_nxt = cur_nxt.addr;
         wen_nxt  = cur_nxt.write;
         if (cur_nxt.write) begin
            wdata_nxt = cur_nxt.wdata;
            ub_nxt    = ~cur_nxt.be[1];
            lb_nxt    = ~cur_nxt.be[0];
         end else begin
            ub_nxt = 1'b0;
            lb_nxt = 1'b0;
         end
         if (state_nxt == ACCESS) begin
            we_nxt = ~cur_nxt.write;
            oe_nxt = cur_nxt.write;
         end
      end
   end

   assign rsp_valid_nxt = (state_nxt == HOLD) ? ((cur.id == REQ_0) ? 2'b01 : 2'b10) : 2'b00;
   assign capture_rdata = (state == ACCESS) && (state_nxt == HOLD) && !cur.write;

   // Sequencer state and the latched request.
   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cur   <= cur_nxt;
      end
   end

   // Registered SRAM pins and response outputs; reset parks strobes high at once.
   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         bus.io_ce               <= 1'b1;
         bus.io_we               <= 1'b1;
         bus.io_oe               <= 1'b1;
         bus.io_ub               <= 1'b1;
         bus.io_lb               <= 1'b1;
         bus.io_data_writeEnable <= 1'b0;
         bus.io_address_0        <= '0;
         bus.io_data_write_0     <= '0;
         bus.rsp_valid           <= 2'b00;
         bus.rsp_rdata           <= '0;
         bus.busy                <= 1'b0;
      end else begin
         bus.io_ce               <= ce_nxt;
         bus.io_we               <= we_nxt;
         bus.io_oe               <= oe_nxt;
         bus.io_ub               <= ub_nxt;
         bus.io_lb               <= lb_nxt;
         bus.io_data_writeEnable <= wen_nxt;
         bus.io_address_0        <= addr_nxt;
         bus.io_data_write_0     <= wdata_nxt;
         bus.rsp_valid           <= rsp_valid_nxt;
         bus.busy                <= (state_nxt != IDLE);
         if (capture_rdata)
            bus.rsp_rdata <= bus.io_data_read;
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: table of single transactions plus hand-written arbitration,
// abort-by-reset and short-timing sequences.
module tb_sram_access_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   sram_access_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
   sram_access_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus2 ();

   sram_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ACCESS_CYCLES(2), .TURNAROUND_CYCLES(1))
      u_dut (.PCLK(clk), .RESET(rst), .bus(bus));

   sram_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ACCESS_CYCLES(1), .TURNAROUND_CYCLES(0))
      u_dut2 (.PCLK(clk), .RESET(rst), .bus(bus2));

   // Small SRAM model behind the default-timing instance (256 words, low address byte).
   logic [15:0] mem [256];
   assign bus.io_data_read  = bus.io_oe ? 16'h0000 : mem[bus.io_address_0[7:0]];
   assign bus2.io_data_read = 16'h0000;

   always @(posedge clk) begin
      if (!rst && !bus.io_ce && !bus.io_we && bus.io_data_writeEnable) begin
         if (!bus.io_ub) mem[bus.io_address_0[7:0]][15:8] <= bus.io_data_write_0[15:8];
         if (!bus.io_lb) mem[bus.io_address_0[7:0]][7:0]  <= bus.io_data_write_0[7:0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Strobe rules hold on every cycle out of reset.
   always @(negedge clk) begin
      if (!rst)
         check("strobe_rules", {30'd0, !bus.io_we && !bus.io_oe, !bus.io_we && bus.io_ce}, 0);
   end

   typedef struct {
      logic        id;
      logic        write;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic        ub;     // expected io_ub while io_ce is low
      logic        lb;     // expected io_lb while io_ce is low
      logic [15:0] rdata;  // expected rsp_rdata in the response cycle
   } vec_t;

   vec_t vecs [7];

   task automatic wait_ready(input logic id, input string name);
      int n = 0;
      #1;
      while (bus.req_ready[id] !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, {31'd0, bus.req_ready[id]}, 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, bus.busy}, 0);
   endtask

   // One transaction from the table; samples cycles 1..6 after the accepting cycle 0.
   task automatic run_vec(input vec_t v, input int idx);
      logic [5:0]  ce_s, we_s, oe_s, ub_s, lb_s, wen_s, rsp_any;
      logic [1:0]  rsp4;
      logic [15:0] rdata4, addr1, wdata1;
      @(negedge clk);
      bus.req_valid        = 2'b00;
      bus.req_valid[v.id]  = 1'b1;
      bus.req_write[v.id]  = v.write;
      if (v.id) begin
         bus.req_addr_1 = v.addr; bus.req_wdata_1 = v.wdata; bus.req_be_1 = v.be;
      end else begin
         bus.req_addr_0 = v.addr; bus.req_wdata_0 = v.wdata; bus.req_be_0 = v.be;
      end
      wait_ready(v.id, $sformatf("v%0d_ready", idx));
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         bus.req_valid = 2'b00;
         #1;
         ce_s[c-1]    = bus.io_ce;
         we_s[c-1]    = bus.io_we;
         oe_s[c-1]    = bus.io_oe;
         ub_s[c-1]    = bus.io_ub;
         lb_s[c-1]    = bus.io_lb;
         wen_s[c-1]   = bus.io_data_writeEnable;
         rsp_any[c-1] = |bus.rsp_valid;
         if (c == 1) begin
            addr1  = bus.io_address_0;
            wdata1 = bus.io_data_write_0;
         end
         if (c == 4) begin
            rsp4   = bus.rsp_valid;
            rdata4 = bus.rsp_rdata;
         end
      end
      check($sformatf("v%0d_ce", idx),  {26'd0, ce_s}, 6'b110000);
      check($sformatf("v%0d_we", idx),  {26'd0, we_s}, v.write ? 6'b111001 : 6'b111111);
      check($sformatf("v%0d_oe", idx),  {26'd0, oe_s}, v.write ? 6'b111111 : 6'b111001);
      check($sformatf("v%0d_wen", idx), {26'd0, wen_s}, v.write ? 6'b001111 : 6'b000000);
      check($sformatf("v%0d_ub", idx),  {26'd0, ub_s}, {26'd0, 2'b11, {4{v.ub}}});
      check($sformatf("v%0d_lb", idx),  {26'd0, lb_s}, {26'd0, 2'b11, {4{v.lb}}});
      check($sformatf("v%0d_rsp_cycle", idx), {26'd0, rsp_any}, 6'b001000);
      check($sformatf("v%0d_rsp_id", idx), {30'd0, rsp4}, v.id ? 2'b10 : 2'b01);
      check($sformatf("v%0d_rdata", idx), {16'd0, rdata4}, {16'd0, v.rdata});
      check($sformatf("v%0d_addr", idx), {16'd0, addr1}, {16'd0, v.addr});
      if (v.write)
         check($sformatf("v%0d_wdata", idx), {16'd0, wdata1}, {16'd0, v.wdata});
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          acc_cyc [4];
      logic        acc_id  [4];
      int          n_acc;
      logic        both_ready, rsp_seen;
      logic [15:0] acc_vec, we_vec, rsp_vec;
      logic [1:0]  rsp3, rsp7;

      vecs[0] = '{1'b0, 1'b1, 16'h1234, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hA5C3};
      vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'h1111, 2'b01, 1'b1, 1'b0, 16'hA5C3};
      vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'h2222, 2'b10, 1'b0, 1'b1, 16'hA5C3};
      vecs[4] = '{1'b0, 1'b1, 16'h0020, 16'h3333, 2'b00, 1'b1, 1'b1, 16'hA5C3};
      vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h2211};
      vecs[6] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hBEEF};

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'hA5C3;

      bus.req_valid = 2'b00;  bus.req_write = 2'b00;
      bus.req_addr_0 = '0;    bus.req_addr_1 = '0;
      bus.req_wdata_0 = '0;   bus.req_wdata_1 = '0;
      bus.req_be_0 = 2'b00;   bus.req_be_1 = 2'b00;
      bus2.req_valid = 2'b00; bus2.req_write = 2'b00;
      bus2.req_addr_0 = '0;   bus2.req_addr_1 = '0;
      bus2.req_wdata_0 = '0;  bus2.req_wdata_1 = '0;
      bus2.req_be_0 = 2'b00;  bus2.req_be_1 = 2'b00;

      // Reset values, with requests already pending to show req_ready stays low.
      repeat (3) @(negedge clk);
      bus.req_valid = 2'b11;
      #1;
      check("rst_strobes", {27'd0, bus.io_ce, bus.io_we, bus.io_oe, bus.io_ub, bus.io_lb}, 5'h1f);
      check("rst_addr", {16'd0, bus.io_address_0}, 0);
      check("rst_wdata", {16'd0, bus.io_data_write_0}, 0);
      check("rst_wen", {31'd0, bus.io_data_writeEnable}, 0);
      check("rst_ready", {30'd0, bus.req_ready}, 0);
      check("rst_rsp", {29'd0, bus.rsp_valid, bus.busy}, 0);
      check("rst_rdata", {16'd0, bus.rsp_rdata}, 0);
      bus.req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Both requesters reading continuously: grants 0,1,0,1 six cycles apart.
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.req_write = 2'b00;
      bus.req_addr_0 = 16'h0010;
      bus.req_addr_1 = 16'h0020;
      n_acc = 0;
      both_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin acc_cyc[k] = -1; acc_id[k] = 1'bx; end
      for (int c = 0; c < 40 && n_acc < 4; c++) begin
         #1;
         if (bus.req_ready == 2'b11) both_ready = 1'b1;
         if (bus.req_ready != 2'b00) begin
            acc_id[n_acc]  = bus.req_ready[1];
            acc_cyc[n_acc] = c;
            n_acc++;
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      check("rr_accept_count", n_acc, 4);
      check("rr_ready_onehot", {31'd0, both_ready}, 0);
      for (int k = 0; k < 4; k++)
         check($sformatf("rr_grant%0d", k), {31'd0, acc_id[k]}, k % 2);
      for (int k = 1; k < 4; k++)
         check($sformatf("rr_spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], 6);
      wait_idle("rr_idle");

      // Single transactions from the table.
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
      wait_idle("table_idle");

      // Reset in the middle of a write's ACCESS phase.
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_write = 2'b01;
      bus.req_addr_0 = 16'h0040;
      bus.req_wdata_0 = 16'h5A5A;
      bus.req_be_0 = 2'b11;
      wait_ready(1'b0, "abort_ready");
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      #1;
      check("abort_pre_we", {31'd0, bus.io_we}, 0);
      #1 rst = 1'b1;
      #1;
      check("abort_we", {31'd0, bus.io_we}, 1);
      check("abort_ce", {31'd0, bus.io_ce}, 1);
      check("abort_wen", {31'd0, bus.io_data_writeEnable}, 0);
      check("abort_busy", {31'd0, bus.busy}, 0);
      rsp_seen = 1'b0;
      repeat (2) begin @(negedge clk); #1; rsp_seen |= |bus.rsp_valid; end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin @(negedge clk); #1; rsp_seen |= |bus.rsp_valid; end
      check("abort_no_rsp", {31'd0, rsp_seen}, 0);
      check("abort_mem_untouched", {16'd0, mem[8'h40]}, 0);
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.req_write = 2'b00;
      #1;
      check("post_reset_grant", {30'd0, bus.req_ready}, 2'b01);
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_idle("post_reset_idle");

      // Short timing instance: ACCESS_CYCLES=1, TURNAROUND_CYCLES=0, both writing.
      @(negedge clk);
      bus2.req_valid = 2'b11;
      bus2.req_write = 2'b11;
      bus2.req_be_0 = 2'b11;
      bus2.req_be_1 = 2'b11;
      bus2.req_wdata_0 = 16'h0F0F;
      bus2.req_wdata_1 = 16'hF0F0;
      acc_vec = '0; we_vec = '0; rsp_vec = '0; rsp3 = 2'b00; rsp7 = 2'b00;
      for (int c = 0; c < 16; c++) begin
         #1;
         acc_vec[c] = |bus2.req_ready;
         we_vec[c]  = !bus2.io_we;
         rsp_vec[c] = |bus2.rsp_valid;
         if (c == 3) rsp3 = bus2.rsp_valid;
         if (c == 7) rsp7 = bus2.rsp_valid;
         @(negedge clk);
      end
      bus2.req_valid = 2'b00;
      check("short_accepts", {16'd0, acc_vec}, 16'h1111);
      check("short_we_low", {16'd0, we_vec}, 16'h4444);
      check("short_rsp_cycles", {16'd0, rsp_vec}, 16'h8888);
      check("short_rsp3", {30'd0, rsp3}, 2'b01);
      check("short_rsp7", {30'd0, rsp7}, 2'b10);
      repeat (4) @(negedge clk);
      check("short_idle", {31'd0, bus2.busy}, 0);

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the external asynchronous 16-bit SRAM pin bundle (address, write data, output-enable for the data bus, CE/WE/OE/UB/LB strobes) between two requesters, e.g. an APB bridge and a test/DMA engine.
- Arbitrates round-robin between the requesters and sequences each access through a timed setup/strobe/hold cycle.
- Returns read data or a write acknowledge to the requester that issued the access.
- Sits between the requester logic and the SRAM pad drivers, replacing ad-hoc pin driving by test processes.

Parameters:
- ADDR_WIDTH, 16, SRAM word-address width.
- DATA_WIDTH, 16, SRAM data width; must be 16 (two byte lanes).
- ACCESS_CYCLES, 2, cycles the WE or OE strobe is held low; must be >= 1.
- TURNAROUND_CYCLES, 1, idle bus cycles after each access before the next grant; may be 0.

Ports:
- PCLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_write  in  2  1 = write, 0 = read, per requester.
- req_addr_0, req_addr_1  in  ADDR_WIDTH each  word address.
- req_wdata_0, req_wdata_1  in  DATA_WIDTH each  write data.
- req_be_0, req_be_1  in  2 each  byte enables for writes; bit1 = upper byte, bit0 = lower byte.
- rsp_valid  out  2  one-cycle completion pulse per requester.
- rsp_rdata  out  DATA_WIDTH  read data; valid only when a rsp_valid bit is high.
- busy  out  1  high whenever the FSM is not in IDLE.
- io_address_0  out  ADDR_WIDTH  SRAM address.
- io_data_write_0  out  DATA_WIDTH  data bus drive value.
- io_data_writeEnable  out  1  pad output-enable for the data bus.
- io_data_read  in  DATA_WIDTH  data bus sampled value.
- io_ce, io_we, io_oe, io_ub, io_lb  out  1 each  SRAM strobes, all active-low.

Behaviour:
- Clocking and reset: single clock PCLK; RESET is asynchronous and active-high; all outputs are registered.
- Reset values:
  - io_ce, io_we, io_oe, io_ub, io_lb = 1.
  - io_address_0 = 0, io_data_write_0 = 0, io_data_writeEnable = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - FSM = IDLE; last_grant = 1, so requester 0 wins first.
- States: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles) -> HOLD -> TURN (TURNAROUND_CYCLES cycles; skipped if 0) -> IDLE.
- IDLE, arbitration:
  - req_ready is a combinational grant: the only valid requester, or, if both are valid, the one that is not last_grant.
  - Handshake is valid & ready. On handshake, latch requester id, write flag, address, data and byte enables, update last_grant, go to SETUP.
- SETUP:
  - io_ce = 0; address driven.
  - Write: io_data_writeEnable = 1, data driven, io_ub = ~be[1], io_lb = ~be[0].
  - Read: io_ub = io_lb = 0.
- ACCESS:
  - Write: io_we = 0. Read: io_oe = 0.
  - Read data io_data_read is captured into rsp_rdata on the last ACCESS cycle edge.
- HOLD:
  - io_we and io_oe return to 1; io_ce, address, write data and io_data_writeEnable are held.
  - rsp_valid[id] pulses high for exactly this cycle.
  - rsp_rdata is valid for reads and holds its last value for writes.
- TURN: io_ce = io_ub = io_lb = 1, io_data_writeEnable = 0.
- Timing with defaults: accept at cycle 0, rsp_valid at cycle 4. Back-to-back accepts are spaced ACCESS_CYCLES + TURNAROUND_CYCLES + 3 cycles (6 with defaults).
- Write with be = 00: the full cycle still runs with io_ub = io_lb = 1, so no bytes are written; the acknowledge is still returned.
- Requests are never dropped or reordered. A requester holding valid while the other wins is served at the next IDLE.
- Request inputs are ignored outside the IDLE handshake cycle.
- Reset mid-operation: strobes return high and io_data_writeEnable goes to 0 immediately (asynchronous); no rsp_valid is produced for the aborted access.
- io_we and io_oe are never low in the same cycle; io_we is low only while io_ce is low.

Decomposition:
- Package sram_arb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, HOLD, TURN);
  - requester index constants REQ_0 = 0, REQ_1 = 1;
  - a latched-request struct (id, write, addr, wdata, be).
- One sub-module, sram_rr_arbiter_2: two-input round-robin grant with a last_grant register and an update enable.

Test Plan:
- Write, requester 0: addr 0x1234, data 0xBEEF, be 11 -> io_ce low cycles 1-4, io_we low exactly cycles 2-3, io_ub = io_lb = 0, io_data_writeEnable high cycles 1-4, rsp_valid = 01 at cycle 4.
- Read, requester 1: addr 0x0010, memory model drives 0xA5C3 -> io_oe low cycles 2-3, io_we stays 1, rsp_valid = 10 with rsp_rdata = 0xA5C3 at cycle 4.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1, accepts 6 cycles apart, req_ready never 11.
- Byte-lane writes:
  - be 01 -> io_lb = 0, io_ub = 1;
  - be 10 -> io_ub = 0, io_lb = 1;
  - be 00 -> both 1, ack still issued.
- RESET asserted mid-ACCESS of a write -> io_we, io_ce return to 1 and io_data_writeEnable to 0 without waiting for a PCLK edge, no rsp_valid; after release, requester 0 is granted first.
- ACCESS_CYCLES = 1, TURNAROUND_CYCLES = 0 -> io_we low for 1 cycle, accepts 4 cycles apart, rsp_valid at cycle 3.
